spi_peripheral_fsm: RTL
=======================

SPI_PERIPHERAL_FSM -- requirements
Module: spi_peripheral_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, memory address width; the address byte is {ADDR_W-bit address, R/W bit}.
REQ-002 SHALL have parameter DATA_W, default 8, shift-register and memory word width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs_n  input  1  conditioned chip select, active low.
REQ-006 sclk_posedge  input  1  one-clk pulse, conditioned SCLK rising edge.
REQ-007 sclk_negedge  input  1  one-clk pulse, conditioned SCLK falling edge.
REQ-008 mosi  input  1  conditioned serial data in.
REQ-009 miso  output  1  serial data out, registered.
REQ-010 miso_oe  output  1  tri-state buffer enable for miso.
REQ-011 mem_addr  output  ADDR_W  address to datamemory.
REQ-012 mem_we  output  1  datamemory write enable, one-clk pulse.
REQ-013 mem_wdata  output  DATA_W  write data to datamemory.
REQ-014 mem_rdata  input  DATA_W  read data, valid one clk after mem_addr is stable.

Function
REQ-015 SHALL implement states IDLE, GET_ADDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE.
REQ-016 IDLE -> GET_ADDR on the clk where cs_n is low; bit counter cleared to 0.
REQ-017 GET_ADDR: on each sclk_posedge, shift mosi into the shift register LSB, MSB first; increment counter.
REQ-018 When the counter reaches DATA_W in GET_ADDR: latch bits [DATA_W-1:1] into mem_addr, clear the counter; bit 0 = 1 -> READ_WAIT, bit 0 = 0 -> WRITE_SHIFT.
REQ-019 READ_WAIT lasts exactly one clk; READ_LOAD loads mem_rdata into the shift register and -> READ_SHIFT.
REQ-020 READ_SHIFT: miso_oe = 1; on each sclk_negedge, miso <= shift register MSB, shift left, increment the counter; at DATA_W -> DONE.
REQ-021 WRITE_SHIFT: shift mosi in on sclk_posedge as in GET_ADDR; at counter = DATA_W -> WRITE_MEM.
REQ-022 WRITE_MEM: mem_wdata = shift register, mem_we = 1 for exactly one clk, then -> DONE.
REQ-023 DONE: hold outputs, miso_oe = 0; -> IDLE when cs_n is high.
REQ-024 cs_n high in any state other than IDLE SHALL force IDLE on the next clk; if it occurs in WRITE_SHIFT, mem_we SHALL NOT assert.
REQ-025 sclk_posedge and sclk_negedge in the same clk: posedge action only.
REQ-026 Edges arriving in READ_WAIT, READ_LOAD, WRITE_MEM or DONE SHALL be ignored.
REQ-027 Counter width SHALL be $clog2(DATA_W)+1 and SHALL never wrap within a transaction.
REQ-028 mem_we SHALL be 0 in all states except WRITE_MEM.

Reset
REQ-029 reset SHALL set the state to IDLE, counter and shift register to 0, miso = 0, miso_oe = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-030 reset SHALL override every other input, including reset asserted mid-transaction.

Structure
REQ-031 State encoding localparams and the R/W bit position SHALL live in a shared package spi_pkg.
REQ-032 The shift register SHALL be the existing shiftregister8; the FSM and counter SHALL stay in this module; no other sub-module.

Verification
REQ-033 Write: address byte 0x54 (addr 0x2A, W), data 0xA5 -> mem_we pulses once with mem_addr = 0x2A and mem_wdata = 0xA5, then DONE.
REQ-034 Read: memory[0x2A] = 0xA5, address byte 0x55 -> miso presents 1,0,1,0,0,1,0,1 on successive sclk_negedge pulses; miso_oe = 1 only during READ_SHIFT.
REQ-035 cs_n rises after 4 write-data bits -> IDLE next clk, mem_we never asserts, and the next transaction works normally.
REQ-036 reset asserted in READ_SHIFT -> all outputs equal the REQ-029 values on the next clk.
REQ-037 Simultaneous sclk_posedge and sclk_negedge in GET_ADDR -> exactly one bit shifted and the counter increments by 1.
REQ-038 Back-to-back write to 0x7F then read from 0x7F with cs_n toggled high between them -> the read returns the written value 0x3C.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI peripheral.
//   - FSM state encodings (3-bit, plain localparams).
//   - Position and polarity of the read/write flag inside the address byte.
package spi_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] StIdle       = 3'd0;
    localparam logic [STATE_W-1:0] StGetAddr    = 3'd1;
    localparam logic [STATE_W-1:0] StReadWait   = 3'd2;
    localparam logic [STATE_W-1:0] StReadLoad   = 3'd3;
    localparam logic [STATE_W-1:0] StReadShift  = 3'd4;
    localparam logic [STATE_W-1:0] StWriteShift = 3'd5;
    localparam logic [STATE_W-1:0] StWriteMem   = 3'd6;
    localparam logic [STATE_W-1:0] StDone       = 3'd7;

    // Address byte layout is {address, rw}; rw = 1 requests a read.
    localparam int unsigned RW_BIT  = 0;
    localparam logic        RW_READ = 1'b1;

endpackage

// File: rtl/shiftregister8.sv
// shiftregister8: parallel-load, serial-in shift register (shifts toward the MSB).
//   clk        system clock
//   reset      synchronous active-high clear
//   load_en    load load_data (takes priority over shift_en)
//   load_data  parallel load value
//   shift_en   shift one position left, shift_in enters at the LSB
//   shift_in   serial input bit
//   q          current register contents
module shiftregister8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = load_data;
        end else if (shift_en) begin
            q_d = {q_q[WIDTH-2:0], shift_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/spi_peripheral_fsm.sv
// spi_peripheral_fsm: SPI peripheral front end for a small data memory.
// A transaction is one address byte {addr, rw} followed by one data byte, MSB first.
// Writes shift the data in on SCLK rising edges and pulse mem_we once; reads fetch
// the word and shift it out on miso on SCLK falling edges.
//   clk           system clock
//   reset         synchronous active-high reset
//   cs_n          chip select, active low; high aborts any transaction
//   sclk_posedge  one-clk pulse per SCLK rising edge
//   sclk_negedge  one-clk pulse per SCLK falling edge
//   mosi          serial data in
//   miso          serial data out (registered)
//   miso_oe       miso driver enable, high only while shifting read data
//   mem_addr      memory address latched from the address byte
//   mem_we        memory write strobe, one clk
//   mem_wdata     memory write data
//   mem_rdata     memory read data, valid one clk after mem_addr settles
module spi_peripheral_fsm
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk_posedge,
    input  logic              sclk_negedge,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // One extra bit so the count can hold DATA_W itself without wrapping.
    localparam int unsigned          CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               miso_q, miso_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic               sr_load;
    logic               sr_shift;
    logic               sr_in;
    logic [DATA_W-1:0]  sr_q;
    logic               neg_act;

    shiftregister8 #(
        .WIDTH (DATA_W)
    ) u_shreg (
        .clk       (clk),
        .reset     (reset),
        .load_en   (sr_load),
        .load_data (mem_rdata),
        .shift_en  (sr_shift),
        .shift_in  (sr_in),
        .q         (sr_q)
    );

    // A falling edge coinciding with a rising edge is dropped.
    assign neg_act = sclk_negedge & ~sclk_posedge;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_in       = mosi;

        if (state_q != StIdle && cs_n) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!cs_n) begin
                        state_d = StGetAddr;
                        cnt_d   = '0;
                    end
                end
                StGetAddr: begin
                    // Full byte is decoded the clk after the last bit; edges then are ignored.
                    if (cnt_q == CNT_FULL) begin
                        mem_addr_d = sr_q[ADDR_W:1];
                        cnt_d      = '0;
                        state_d    = (sr_q[RW_BIT] == RW_READ) ? StReadWait : StWriteShift;
                    end else if (sclk_posedge) begin
                        sr_shift = 1'b1;
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
                StReadWait: begin
                    state_d = StReadLoad;
                end
                StReadLoad: begin
                    sr_load = 1'b1;
                    state_d = StReadShift;
                end
                StReadShift: begin
                    if (cnt_q == CNT_FULL) begin
                        state_d = StDone;
                    end else if (neg_act) begin
                        miso_d   = sr_q[DATA_W-1];
                        sr_shift = 1'b1;
                        sr_in    = 1'b0;
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
                StWriteShift: begin
                    if (cnt_q == CNT_FULL) begin
                        mem_wdata_d = sr_q;
                        state_d     = StWriteMem;
                    end else if (sclk_posedge) begin
                        sr_shift = 1'b1;
                        cnt_d    = cnt_q + CNT_ONE;
                    end
                end
                StWriteMem: begin
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = (state_q == StReadShift);
    assign mem_we    = (state_q == StWriteMem);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
